// File: rtl/rv_mt_pkg.sv
// Shared types and sizing for the multithreaded RV core: hart count,
// per-hart run state and the in-flight pipe entry.
package rv_mt_pkg;

    localparam int NHARTS = 8;
    localparam int HART_W = $clog2(NHARTS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2
    } hart_state_t;

    typedef struct packed {
        logic              valid;
        logic [HART_W-1:0] hart;
    } inflight_t;

endpackage

// File: rtl/rv_rr_arb.sv
// Combinational rotating-priority picker: grants the first requester at or
// above ptr, wrapping modulo N. N must be a power of two equal to 2**W.
module rv_rr_arb
    import rv_mt_pkg::*;
#(
    parameter int N = NHARTS,
    parameter int W = HART_W
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         gnt_valid,
    output logic [W-1:0] gnt_id
);

    logic [W-1:0] idx;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = ptr;
        idx       = ptr;
        for (int k = 0; k < N; k++) begin
            // W-bit addition wraps the search around the top of the range
            idx = ptr + W'(k);
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_id    = idx;
            end
        end
    end

endmodule

// File: rtl/rv_hart_sched.sv
// Barrel-thread scheduler: round-robin issue over RUN harts with at most one
// instruction per hart in flight, and the matching hart ID at writeback.
module rv_hart_sched
    import rv_mt_pkg::*;
#(
    parameter int                PIPE_DEPTH     = 4,
    parameter logic [NHARTS-1:0] RESET_RUN_MASK = NHARTS'(8'h01)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NHARTS-1:0] hart_start,
    input  logic [NHARTS-1:0] hart_stop,
    input  logic [NHARTS-1:0] hart_block,
    input  logic [NHARTS-1:0] hart_wake,
    output logic              issue_valid,
    output logic [HART_W-1:0] issue_hart,
    output logic              wb_valid,
    output logic [HART_W-1:0] wb_hart,
    output logic              pc_en,
    output logic [NHARTS-1:0] run_mask,
    output logic [NHARTS-1:0] inflight_mask
);

    // The issue cycle is the first of the PIPE_DEPTH cycles, so only
    // PIPE_DEPTH-1 registered slots follow it; the last one is writeback.
    localparam int WB = PIPE_DEPTH - 2;

    hart_state_t       state  [NHARTS];
    inflight_t         slot_p [PIPE_DEPTH-1];
    logic [HART_W-1:0] rr_ptr;
    logic [NHARTS-1:0] eligible;
    logic              gnt_valid;
    logic [HART_W-1:0] gnt_id;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NHARTS; i++) begin
            if (rst) begin
                state[i] <= RESET_RUN_MASK[i] ? RUN : IDLE;
            end else if (hart_stop[i]) begin
                state[i] <= IDLE;
            end else begin
                case (state[i])
                    IDLE:    if (hart_start[i]) state[i] <= RUN;
                    RUN:     if (hart_block[i] && !hart_wake[i]) state[i] <= WAIT;
                    WAIT:    if (hart_wake[i]) state[i] <= RUN;
                    default: state[i] <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NHARTS; i++) run_mask[i] = (state[i] == RUN);
    end

    // The writeback slot is excluded so a hart can reissue as it retires.
    always_comb begin
        inflight_mask = '0;
        for (int s = 0; s < WB; s++) begin
            if (slot_p[s].valid) inflight_mask[slot_p[s].hart] = 1'b1;
        end
    end

    assign eligible = {NHARTS{en}} & run_mask & ~inflight_mask;

    rv_rr_arb #(
        .N (NHARTS),
        .W (HART_W)
    ) u_arb (
        .req       (eligible),
        .ptr       (rr_ptr),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // Issue stage -> slot 0; slots shift toward writeback only when en=1.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < PIPE_DEPTH - 1; s++) slot_p[s].valid <= 1'b0;
            rr_ptr <= '0;
        end else if (en) begin
            slot_p[0].valid <= gnt_valid;
            slot_p[0].hart  <= gnt_id;
            for (int s = 1; s < PIPE_DEPTH - 1; s++) slot_p[s] <= slot_p[s-1];
            if (gnt_valid) rr_ptr <= gnt_id + HART_W'(1);
        end
    end

    // Writeback stage outputs.
    assign issue_valid = gnt_valid & ~rst;
    assign issue_hart  = gnt_id;
    assign wb_valid    = slot_p[WB].valid & ~rst;
    assign wb_hart     = slot_p[WB].hart;
    assign pc_en       = wb_valid & en;

endmodule
